preif_if_pipe: RTL

- Parametrised pre-IF → IF pipeline register, successor to the fixed two-PC stage.
- Carries FETCH_WIDTH PCs per fetch group and a valid/allowin handshake with flush kill.
- Holds returned instruction-RAM data in a BUF_DEPTH-entry FIFO rather than a single register.
- Tracks outstanding to-be-discarded responses with a saturating counter of depth CANCEL_MAX rather than a fixed 3-state FSM.

---
 rtl/preif_if_pipe_if.sv | 51 +++++
 rtl/preif_if_pipe.sv | 138 +++++++++++++
 2 files changed

// File: rtl/preif_if_pipe_if.sv
// Pre-IF -> IF pipeline bundle: PC group handshake, rdata buffer and cancel tracking.
// PREIF_IF_CANCEL_OVF_EN adds the sticky overflow flags cancel_ovf_o and buf_ovf_o.
interface preif_if_pipe_if #(
   parameter int FETCH_WIDTH = 2,
   parameter int PC_W        = 32,
   parameter int RDATA_W     = 64,
   parameter int CANCEL_MAX  = 3
) ();
   localparam int CNT_W = $clog2(CANCEL_MAX + 1);

   logic                        preif_to_if_valid_i;
   logic                        if_allowin_i;
   logic                        if_valid_o;
   logic                        excep_flush_i;
   logic                        banch_flush_i;
   logic [FETCH_WIDTH*PC_W-1:0] preif_to_ibus;
   logic [FETCH_WIDTH*PC_W-1:0] to_if_obus;
   logic                        buf_push_i;
   logic [RDATA_W-1:0]          buf_wdata_i;
   logic                        buf_pop_i;
   logic [RDATA_W-1:0]          buf_rdata_o;
   logic                        buf_valid_o;
   logic                        buf_full_o;
   logic [1:0]                  inst_rdata_ce_we_i;
   logic                        inst_rdata_ce_o;
   logic [CNT_W-1:0]            cancel_cnt_o;
`ifdef PREIF_IF_CANCEL_OVF_EN
   logic                        cancel_ovf_o;
   logic                        buf_ovf_o;
`endif

   modport master (
      output preif_to_if_valid_i, if_allowin_i, excep_flush_i, banch_flush_i, preif_to_ibus,
             buf_push_i, buf_wdata_i, buf_pop_i, inst_rdata_ce_we_i,
      input  if_valid_o, to_if_obus, buf_rdata_o, buf_valid_o, buf_full_o,
             inst_rdata_ce_o, cancel_cnt_o
`ifdef PREIF_IF_CANCEL_OVF_EN
      , input cancel_ovf_o, buf_ovf_o
`endif
   );

   modport slave (
      input  preif_to_if_valid_i, if_allowin_i, excep_flush_i, banch_flush_i, preif_to_ibus,
             buf_push_i, buf_wdata_i, buf_pop_i, inst_rdata_ce_we_i,
      output if_valid_o, to_if_obus, buf_rdata_o, buf_valid_o, buf_full_o,
             inst_rdata_ce_o, cancel_cnt_o
`ifdef PREIF_IF_CANCEL_OVF_EN
      , output cancel_ovf_o, buf_ovf_o
`endif
   );
endinterface

// File: rtl/preif_if_pipe.sv
// Pre-IF -> IF pipeline register with rdata FIFO and saturating discard counter.
// Optional sticky overflow flags under PREIF_IF_CANCEL_OVF_EN.
module preif_if_pipe #(
   parameter int              FETCH_WIDTH = 2,
   parameter int              PC_W        = 32,
   parameter logic [PC_W-1:0] RESET_PC    = 32'h1c00_0000,
   parameter int              RDATA_W     = 64,
   parameter int              BUF_DEPTH   = 2,
   parameter int              CANCEL_MAX  = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   preif_if_pipe_if.slave bus
);
   localparam int BUS_W = FETCH_WIDTH * PC_W;
   localparam int CNT_W = $clog2(CANCEL_MAX + 1);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   // Lanes count down from RESET_PC so the last lane holds RESET_PC itself.
   function automatic logic [BUS_W-1:0] reset_bus();
      logic [BUS_W-1:0] v;
      v = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         v[i*PC_W +: PC_W] = RESET_PC - PC_W'(32'd4 * unsigned'(FETCH_WIDTH - 1 - i));
      end
      return v;
   endfunction

   localparam logic [BUS_W-1:0] RESET_BUS = reset_bus();

   logic [BUS_W-1:0]   pc_r;
   logic               valid_r;
   logic [RDATA_W-1:0] mem_r [BUF_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [OCC_W-1:0]   occ_r, occ_nxt_s;
   logic [RDATA_W-1:0] head_r, head_nxt_s;
   logic               buf_valid_r, buf_full_r, push_s, pop_s;
   logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
   logic               ce_r;
`ifdef PREIF_IF_CANCEL_OVF_EN
   logic               cancel_ovf_r, buf_ovf_r;
`endif

   // PC group register and live-group flag; flush wins over a same-cycle load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_r    <= RESET_BUS;
         valid_r <= 1'b0;
      end else begin
         if (bus.preif_to_if_valid_i && bus.if_allowin_i) pc_r <= bus.preif_to_ibus;
         if (bus.excep_flush_i || bus.banch_flush_i) valid_r <= 1'b0;
         else if (bus.if_allowin_i)                  valid_r <= bus.preif_to_if_valid_i;
      end
   end

   // FIFO next state; a push to a full buffer only lands when a pop frees the slot.
   always_comb begin
      push_s       = bus.buf_push_i && (!buf_full_r || bus.buf_pop_i);
      pop_s        = bus.buf_pop_i && buf_valid_r;
      wr_ptr_nxt_s = push_s ? wr_ptr_r + PTR_W'(1'b1) : wr_ptr_r;
      rd_ptr_nxt_s = pop_s  ? rd_ptr_r + PTR_W'(1'b1) : rd_ptr_r;
      case ({push_s, pop_s})
         2'b10:   occ_nxt_s = occ_r + OCC_W'(1'b1);
         2'b01:   occ_nxt_s = occ_r - OCC_W'(1'b1);
         default: occ_nxt_s = occ_r;
      endcase
      if (occ_nxt_s == OCC_W'(0))                head_nxt_s = '0;
      else if (push_s && rd_ptr_nxt_s == wr_ptr_r) head_nxt_s = bus.buf_wdata_i;
      else                                       head_nxt_s = mem_r[rd_ptr_nxt_s];
   end

   // FIFO storage; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (rst_n && push_s) mem_r[wr_ptr_r] <= bus.buf_wdata_i;
   end

   // FIFO pointers, occupancy and registered head/status.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         occ_r       <= '0;
         head_r      <= '0;
         buf_valid_r <= 1'b0;
         buf_full_r  <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         occ_r       <= occ_nxt_s;
         head_r      <= head_nxt_s;
         buf_valid_r <= (occ_nxt_s != OCC_W'(0));
         buf_full_r  <= (occ_nxt_s == OCC_W'(BUF_DEPTH));
      end
   end

   // Saturating discard counter next state.
   always_comb begin
      case (bus.inst_rdata_ce_we_i)
         2'b10:   cnt_nxt_s = (cnt_r == CNT_W'(CANCEL_MAX)) ? cnt_r : cnt_r + CNT_W'(1'b1);
         2'b01:   cnt_nxt_s = (cnt_r == CNT_W'(0)) ? cnt_r : cnt_r - CNT_W'(1'b1);
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Discard counter, its registered non-zero flag and optional sticky overflows.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r        <= '0;
         ce_r         <= 1'b0;
`ifdef PREIF_IF_CANCEL_OVF_EN
         cancel_ovf_r <= 1'b0;
         buf_ovf_r    <= 1'b0;
`endif
      end else begin
         cnt_r        <= cnt_nxt_s;
         ce_r         <= (cnt_nxt_s != CNT_W'(0));
`ifdef PREIF_IF_CANCEL_OVF_EN
         if ((bus.inst_rdata_ce_we_i == 2'b10 && cnt_r == CNT_W'(CANCEL_MAX)) ||
             (bus.inst_rdata_ce_we_i == 2'b01 && cnt_r == CNT_W'(0)))
            cancel_ovf_r <= 1'b1;
         if (bus.buf_push_i && buf_full_r && !bus.buf_pop_i) buf_ovf_r <= 1'b1;
`endif
      end
   end

   assign bus.to_if_obus      = pc_r;
   assign bus.if_valid_o      = valid_r;
   assign bus.buf_rdata_o     = head_r;
   assign bus.buf_valid_o     = buf_valid_r;
   assign bus.buf_full_o      = buf_full_r;
   assign bus.cancel_cnt_o    = cnt_r;
   assign bus.inst_rdata_ce_o = ce_r;
`ifdef PREIF_IF_CANCEL_OVF_EN
   assign bus.cancel_ovf_o    = cancel_ovf_r;
   assign bus.buf_ovf_o       = buf_ovf_r;
`endif
endmodule
